// File: rtl/sonar_varredura_ctrl.sv
// Sweep controller for a servo-mounted sonar: position, measure, transmit,
// then step the servo ping-pong over positions 0..7 and back.
//
// Parameters:
//   SETTLE_CYCLES  - servo settle wait per position, in clocks
//   TIMEOUT_CYCLES - longest wait for a measurement, in clocks
// Ports:
//   clock          - system clock; all state changes on the rising edge
//   reset          - asynchronous, active-low
//   ligar          - level enable of the sweep
//   parar          - level pause request, acted on between positions
//   medida_pronto  - one-cycle pulse: measurement finished
//   envio_pronto   - one-cycle pulse: serial transmission finished
//   posicao        - servo / angle-ROM address
//   medir          - one-cycle measurement start pulse
//   transmitir     - one-cycle transmit start pulse
//   timeout        - one-cycle pulse when a measurement times out
//   fim_posicao    - one-cycle pulse when a position completes
//   db_estado      - current state code, for debug
// Build option:
//   SONAR_VARREDURA_TIMEOUT_EN - when defined, builds the measurement
//   timeout counter; otherwise the controller waits for medida_pronto
//   forever and timeout stays 0.

module sonar_varredura_ctrl #(
    parameter int SETTLE_CYCLES  = 25000000,
    parameter int TIMEOUT_CYCLES = 150000000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ligar,
    input  logic       parar,
    input  logic       medida_pronto,
    input  logic       envio_pronto,
    output logic [2:0] posicao,
    output logic       medir,
    output logic       transmitir,
    output logic       timeout,
    output logic       fim_posicao,
    output logic [3:0] db_estado
);

    localparam logic [2:0] INICIAL        = 3'd0;
    localparam logic [2:0] POSICIONA      = 3'd1;
    localparam logic [2:0] MEDE           = 3'd2;
    localparam logic [2:0] AGUARDA_MEDIDA = 3'd3;
    localparam logic [2:0] TRANSMITE      = 3'd4;
    localparam logic [2:0] AGUARDA_ENVIO  = 3'd5;
    localparam logic [2:0] PROXIMA        = 3'd6;
    localparam logic [2:0] PAUSA          = 3'd7;

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    logic [2:0]    state_q, state_d;
    logic [2:0]    pos_q, pos_d;
    logic          desc_q, desc_d;
    logic [SW-1:0] settle_q, settle_d;
    logic          to_hit;

`ifdef SONAR_VARREDURA_TIMEOUT_EN
    localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] to_q, to_d;

    assign to_hit = (state_q == AGUARDA_MEDIDA) && (to_q == TO_LAST);
    // medida_pronto arriving on the last allowed cycle still counts
    assign timeout = to_hit && !medida_pronto;

    // Runs only while staying in AGUARDA_MEDIDA, so it is zero on entry
    always_comb begin
        to_d = '0;
        if (state_q == AGUARDA_MEDIDA && state_d == AGUARDA_MEDIDA)
            to_d = to_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) to_q <= '0;
        else        to_q <= to_d;
    end
`else
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        pos_d   = pos_q;
        desc_d  = desc_q;
        unique case (state_q)
            INICIAL:
                if (ligar) state_d = POSICIONA;
            POSICIONA:
                if (settle_q == SETTLE_LAST) state_d = MEDE;
            MEDE:
                state_d = AGUARDA_MEDIDA;
            AGUARDA_MEDIDA:
                if (medida_pronto) state_d = TRANSMITE;
                else if (to_hit)   state_d = PROXIMA;
            TRANSMITE:
                state_d = AGUARDA_ENVIO;
            AGUARDA_ENVIO:
                if (envio_pronto) state_d = PROXIMA;
            PROXIMA: begin
                // Direction flips on arrival at an end: 6,7,6 and 1,0,1
                if (!desc_q) begin
                    pos_d = pos_q + 3'd1;
                    if (pos_q == 3'd6) desc_d = 1'b1;
                end else begin
                    pos_d = pos_q - 3'd1;
                    if (pos_q == 3'd1) desc_d = 1'b0;
                end
                if (!ligar)     state_d = INICIAL;
                else if (parar) state_d = PAUSA;
                else            state_d = POSICIONA;
            end
            PAUSA:
                if (!ligar)      state_d = INICIAL;
                else if (!parar) state_d = POSICIONA;
            default:
                state_d = INICIAL;
        endcase
    end

    // Runs only while staying in POSICIONA, so it is zero on entry
    always_comb begin
        settle_d = '0;
        if (state_q == POSICIONA && state_d == POSICIONA)
            settle_d = settle_q + 1'b1;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= INICIAL;
            pos_q    <= 3'd0;
            desc_q   <= 1'b0;
            settle_q <= '0;
        end else begin
            state_q  <= state_d;
            pos_q    <= pos_d;
            desc_q   <= desc_d;
            settle_q <= settle_d;
        end
    end

    assign posicao     = pos_q;
    assign medir       = (state_q == MEDE);
    assign transmitir  = (state_q == TRANSMITE);
    assign fim_posicao = (state_q == PROXIMA);
    assign db_estado   = {1'b0, state_q};

endmodule

// File: tb/tb_sonar_varredura_ctrl.sv
// Self-checking bench for sonar_varredura_ctrl (SETTLE=4, TIMEOUT=10).
// Checks every cycle against a position-level timeline model.

module tb_sonar_varredura_ctrl;

    localparam int S = 4;
    localparam int T = 10;
`ifdef SONAR_VARREDURA_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic       clock = 1'b0;
    logic       reset;
    logic       ligar, parar, medida_pronto, envio_pronto;
    logic [2:0] posicao;
    logic       medir, transmitir, timeout, fim_posicao;
    logic [3:0] db_estado;

    int errors = 0;
    int checks = 0;
    int k = 0;

    sonar_varredura_ctrl #(
        .SETTLE_CYCLES (S),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .ligar        (ligar),
        .parar        (parar),
        .medida_pronto(medida_pronto),
        .envio_pronto (envio_pronto),
        .posicao      (posicao),
        .medir        (medir),
        .transmitir   (transmitir),
        .timeout      (timeout),
        .fim_posicao  (fim_posicao),
        .db_estado    (db_estado)
    );

    always #5 clock = ~clock;

    // n-th visited position of a 0..7..0 ping-pong (period 14)
    function automatic logic [2:0] pos_of(int n);
        int m = n % 14;
        return (m <= 7) ? 3'(m) : 3'(14 - m);
    endfunction

    function automatic logic [10:0] ev(int st, logic [2:0] p,
                                       bit m, bit t, bit o, bit f);
        return {4'(st), p, m, t, o, f};
    endfunction

    task automatic chk(string nm, logic [10:0] exp);
        logic [10:0] act;
        act = {db_estado, posicao, medir, transmitir, timeout, fim_posicao};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got st=%0d pos=%0d mtof=%b want st=%0d pos=%0d mtof=%b",
                     nm, $time, act[10:7], act[6:4], act[3:0],
                     exp[10:7], exp[6:4], exp[3:0]);
        end
    endtask

    // One full position, starting at its first POSICIONA cycle.
    // dm: cycles from medir to medida_pronto; de: transmitir to envio_pronto.
    task automatic run_position(int dm, int de, bit p_end, bit l_end,
                                bit tmo, bit noise);
        int r, e, last, st;
        logic [2:0] p;
        r    = tmo ? S + T : S + dm;
        e    = r + 1 + de;
        last = tmo ? r + 1 : e + 1;
        p    = pos_of(k);
        for (int i = 0; i <= last; i++) begin
            @(negedge clock);
            medida_pronto = (i == S + dm);
            envio_pronto  = (!tmo && i == e);
            parar = 1'b0;
            ligar = 1'b1;
            if (noise) begin
                if (i < S) begin
                    medida_pronto = 1'($urandom % 2);
                    envio_pronto  = 1'($urandom % 2);
                end
                parar = 1'($urandom % 2);
                ligar = 1'($urandom % 2);
            end
            if (i == last) begin
                parar = p_end;
                ligar = l_end;
            end
            #1;
            if (i < S)        st = 1;
            else if (i == S)  st = 2;
            else if (i <= r)  st = 3;
            else if (tmo)     st = 6;
            else if (i == r + 1) st = 4;
            else if (i <= e)  st = 5;
            else              st = 6;
            chk("position", ev(st, p, i == S, !tmo && i == r + 1,
                               tmo && i == r, i == last));
        end
        k++;
    endtask

    // INICIAL for n cycles; ligar rises on the last one
    task automatic idle(int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            medida_pronto = 1'($urandom % 2);
            envio_pronto  = 1'($urandom % 2);
            parar = 1'($urandom % 2);
            ligar = (i == n - 1);
            #1;
            chk("idle", ev(0, pos_of(k), 0, 0, 0, 0));
        end
    endtask

    // PAUSA for n cycles; leaves to POSICIONA, or to INICIAL if to_idle
    task automatic pause_hold(int n, bit to_idle);
        for (int i = 0; i < n; i++) begin
            @(negedge clock);
            medida_pronto = 1'($urandom % 2);
            envio_pronto  = 1'($urandom % 2);
            parar = 1'b1;
            ligar = 1'b1;
            if (i == n - 1) begin
                parar = to_idle ? 1'($urandom % 2) : 1'b0;
                ligar = !to_idle;
            end
            #1;
            chk("pause", ev(7, pos_of(k), 0, 0, 0, 0));
        end
    endtask

    typedef struct {
        int dm;
        int de;
        bit p_end;
        bit l_end;
        bit exp_to;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{dm: 3,  de: 2, p_end: 0, l_end: 1, exp_to: 0};
        tbl[1] = '{dm: 1,  de: 1, p_end: 0, l_end: 1, exp_to: 0};
        tbl[2] = '{dm: 10, de: 1, p_end: 0, l_end: 1, exp_to: 0};
        tbl[3] = '{dm: 9,  de: 3, p_end: 0, l_end: 1, exp_to: 0};
        tbl[4] = '{dm: 11, de: 1, p_end: 0, l_end: 1, exp_to: TO_EN};
        tbl[5] = '{dm: 20, de: 1, p_end: 0, l_end: 1, exp_to: TO_EN};
        tbl[6] = '{dm: 2,  de: 2, p_end: 1, l_end: 1, exp_to: 0};
        tbl[7] = '{dm: 5,  de: 1, p_end: 0, l_end: 0, exp_to: 0};

        ligar = 0; parar = 0; medida_pronto = 0; envio_pronto = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clock);
        #1 chk("reset", ev(0, 3'd0, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b1;
        #1 chk("reset_release", ev(0, 3'd0, 0, 0, 0, 0));
        idle(3);

        for (int v = 0; v < 8; v++) begin
            run_position(tbl[v].dm, tbl[v].de, tbl[v].p_end,
                         tbl[v].l_end, tbl[v].exp_to, 1'b0);
            if (!tbl[v].l_end)     idle(3);
            else if (tbl[v].p_end) pause_hold(4, 1'b0);
        end

        for (int n = 0; n < 40; n++) begin
            int dm, de, sel;
            bit tmo, p_end, l_end, ti;
            dm = TO_EN ? int'($urandom_range(1, T + 3))
                       : int'($urandom_range(1, 15));
            de = int'($urandom_range(1, 4));
            tmo = TO_EN && (dm > T);
            sel = int'($urandom % 8);
            p_end = (sel == 0);
            l_end = (sel != 1);
            run_position(dm, de, p_end, l_end, tmo, 1'b1);
            if (!l_end) idle(int'($urandom_range(1, 3)));
            else if (p_end) begin
                ti = 1'($urandom % 2);
                pause_hold(int'($urandom_range(1, 4)), ti);
                if (ti) idle(int'($urandom_range(1, 3)));
            end
        end

        for (int g = 0; g < 20 && pos_of(k) != 3'd5; g++)
            run_position(2, 1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i <= S + 2; i++) begin
            @(negedge clock);
            medida_pronto = 0; envio_pronto = 0;
            parar = 0; ligar = 1;
        end
        #1 chk("wait_meas_pos5", ev(3, 3'd5, 0, 0, 0, 0));
        @(negedge clock);
        reset = 1'b0;
        medida_pronto = 1'b1;
        envio_pronto  = 1'b1;
        #1 chk("async_reset", ev(0, 3'd0, 0, 0, 0, 0));
        for (int i = 0; i < 2; i++) begin
            @(negedge clock);
            #1 chk("held_reset", ev(0, 3'd0, 0, 0, 0, 0));
        end
        @(negedge clock);
        reset = 1'b1;
        ligar = 1'b0;
        #1 chk("post_reset", ev(0, 3'd0, 0, 0, 0, 0));
        k = 0;
        idle(3);
        run_position(3, 2, 1'b0, 1'b1, 1'b0, 1'b0);
        run_position(4, 1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
